// File: rtl/uart_cfg_core.sv
// UART core with runtime baud divisor, 5-8 bit characters, parity and stop-bit selection,
// and a receive FIFO carrying per-entry parity/framing error flags plus a sticky overrun flag.
`timescale 1ns/1ps
module uart_cfg_core #(
   parameter int DIV_WIDTH = 16,
   parameter int RX_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic [1:0]           cfg_data_bits,
   input  logic [1:0]           cfg_parity,
   input  logic                 cfg_stop2,
   input  logic                 rx,
   output logic                 tx,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [7:0]           tx_data,
   output logic                 tx_busy,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic [7:0]           rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   input  logic                 clr_err
);

   localparam int PW = $clog2(RX_DEPTH);
   localparam logic [PW:0] FULL_CNT = RX_DEPTH[PW:0];

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   // Valid/ready: a transfer happens in any cycle where valid and ready are both 1;
   // tx_ready / rx_valid never depend combinationally on tx_valid / rx_ready.

   // ---------------- oversample tick ----------------
   logic [DIV_WIDTH-1:0] tick_cnt;
   logic [DIV_WIDTH-1:0] div_q;
   logic                 tick;

   assign tick = (tick_cnt == div_q);

   // The divisor is resampled only on wrap, so a change never shortens a running period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
         div_q    <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
         div_q    <= divisor;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // ---------------- transmitter ----------------
   logic [2:0] tx_state;
   logic       tx_q;
   logic       tx_armed;
   logic [4:0] tx_tcnt;
   logic [2:0] tx_bcnt;
   logic [2:0] tx_last;
   logic [7:0] tx_shift;
   logic       tx_par_en;
   logic       tx_par_bit;
   logic       tx_stop2;
   logic [7:0] tx_masked;
   logic [4:0] tx_stop_last;

   assign tx_masked    = tx_data & (8'hFF >> (2'd3 - cfg_data_bits));
   assign tx_stop_last = tx_stop2 ? 5'd31 : 5'd15;
   assign tx           = tx_q;
   assign tx_ready     = (tx_state == S_IDLE);
   assign tx_busy      = (tx_state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state   <= S_IDLE;
         tx_q       <= 1'b1;
         tx_armed   <= 1'b0;
         tx_tcnt    <= '0;
         tx_bcnt    <= '0;
         tx_last    <= '0;
         tx_shift   <= '0;
         tx_par_en  <= 1'b0;
         tx_par_bit <= 1'b0;
         tx_stop2   <= 1'b0;
      end else begin
         case (tx_state)
            S_IDLE: begin
               tx_q <= 1'b1;
               if (tx_valid) begin
                  tx_shift   <= tx_masked;
                  tx_last    <= {1'b1, cfg_data_bits};
                  tx_par_en  <= ^cfg_parity;
                  tx_par_bit <= (^tx_masked) ^ (cfg_parity == 2'b10);
                  tx_stop2   <= cfg_stop2;
                  tx_armed   <= 1'b0;
                  tx_tcnt    <= '0;
                  tx_bcnt    <= '0;
                  tx_state   <= S_START;
               end
            end
            S_START: if (tick) begin
               // First tick after accept only drops the line; the bit period starts there.
               if (!tx_armed) begin
                  tx_armed <= 1'b1;
                  tx_q     <= 1'b0;
                  tx_tcnt  <= '0;
               end else if (tx_tcnt == 5'd15) begin
                  tx_tcnt  <= '0;
                  tx_q     <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_bcnt  <= '0;
                  tx_state <= S_DATA;
               end else begin
                  tx_tcnt <= tx_tcnt + 1'b1;
               end
            end
            S_DATA: if (tick) begin
               if (tx_tcnt == 5'd15) begin
                  tx_tcnt <= '0;
                  if (tx_bcnt == tx_last) begin
                     tx_q     <= tx_par_en ? tx_par_bit : 1'b1;
                     tx_state <= tx_par_en ? S_PARITY : S_STOP;
                  end else begin
                     tx_bcnt  <= tx_bcnt + 1'b1;
                     tx_q     <= tx_shift[0];
                     tx_shift <= tx_shift >> 1;
                  end
               end else begin
                  tx_tcnt <= tx_tcnt + 1'b1;
               end
            end
            S_PARITY: if (tick) begin
               if (tx_tcnt == 5'd15) begin
                  tx_tcnt  <= '0;
                  tx_q     <= 1'b1;
                  tx_state <= S_STOP;
               end else begin
                  tx_tcnt <= tx_tcnt + 1'b1;
               end
            end
            S_STOP: if (tick) begin
               if (tx_tcnt == tx_stop_last) begin
                  tx_tcnt  <= '0;
                  tx_state <= S_IDLE;
               end else begin
                  tx_tcnt <= tx_tcnt + 1'b1;
               end
            end
            default: tx_state <= S_IDLE;
         endcase
      end
   end

   // ---------------- receiver ----------------
   logic       rx_s1, rx_s2;
   logic [2:0] rx_state;
   logic [3:0] rx_tcnt;
   logic [3:0] rx_bt;
   logic [2:0] rx_bcnt;
   logic [2:0] rx_last;
   logic [1:0] rx_dbits;
   logic       rx_par_en;
   logic       rx_par_odd;
   logic [7:0] rx_shift;
   logic [1:0] rx_smp;
   logic       rx_perr;
   logic       rx_maj;
   logic [7:0] rx_data_rj;
   logic       rx_push;
   logic [9:0] rx_push_ent;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
      end
   end

   // rx_bt is the index of the current tick within the bit, counted from the start edge.
   assign rx_bt      = rx_tcnt + 4'd1;
   assign rx_maj     = (rx_smp[0] & rx_smp[1]) | (rx_smp[0] & rx_s2) | (rx_smp[1] & rx_s2);
   assign rx_data_rj = rx_shift >> (2'd3 - rx_dbits);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state    <= S_IDLE;
         rx_tcnt     <= '0;
         rx_bcnt     <= '0;
         rx_last     <= '0;
         rx_dbits    <= '0;
         rx_par_en   <= 1'b0;
         rx_par_odd  <= 1'b0;
         rx_shift    <= '0;
         rx_smp      <= '0;
         rx_perr     <= 1'b0;
         rx_push     <= 1'b0;
         rx_push_ent <= '0;
      end else begin
         rx_push <= 1'b0;
         if (tick) begin
            if (rx_state != S_IDLE) rx_tcnt <= rx_bt;
            if (rx_bt == 4'd7) rx_smp[0] <= rx_s2;
            if (rx_bt == 4'd8) rx_smp[1] <= rx_s2;
            case (rx_state)
               S_IDLE: if (!rx_s2) begin
                  rx_state   <= S_START;
                  rx_tcnt    <= '0;
                  rx_bcnt    <= '0;
                  rx_last    <= {1'b1, cfg_data_bits};
                  rx_dbits   <= cfg_data_bits;
                  rx_par_en  <= ^cfg_parity;
                  rx_par_odd <= (cfg_parity == 2'b10);
                  rx_perr    <= 1'b0;
               end
               S_START: begin
                  if (rx_bt == 4'd8 && rx_s2) rx_state <= S_IDLE;
                  else if (rx_bt == 4'd15)    rx_state <= S_DATA;
               end
               S_DATA: begin
                  if (rx_bt == 4'd9) rx_shift <= {rx_maj, rx_shift[7:1]};
                  if (rx_bt == 4'd15) begin
                     if (rx_bcnt == rx_last) rx_state <= rx_par_en ? S_PARITY : S_STOP;
                     else                    rx_bcnt  <= rx_bcnt + 1'b1;
                  end
               end
               S_PARITY: begin
                  if (rx_bt == 4'd9)  rx_perr  <= rx_maj ^ (^rx_data_rj) ^ rx_par_odd;
                  if (rx_bt == 4'd15) rx_state <= S_STOP;
               end
               S_STOP: if (rx_bt == 4'd9) begin
                  // Leave right after the first stop bit so back-to-back frames are caught.
                  rx_push     <= 1'b1;
                  rx_push_ent <= {rx_data_rj, rx_perr, ~rx_maj};
                  rx_state    <= S_IDLE;
               end
               default: rx_state <= S_IDLE;
            endcase
         end
      end
   end

   // ---------------- receive FIFO ----------------
   logic [9:0]    mem [RX_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          full, pop, wr_en, ovr_q;
   logic [9:0]    head;

   assign full     = (count == FULL_CNT);
   assign rx_valid = (count != '0);
   assign pop      = rx_valid & rx_ready;
   assign wr_en    = rx_push & (~full | pop);
   assign head     = mem[rd_ptr];

   assign rx_data       = rx_valid ? head[9:2] : 8'h00;
   assign rx_parity_err = rx_valid & head[1];
   assign rx_frame_err  = rx_valid & head[0];
   assign rx_overrun    = ovr_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= rx_push_ent;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovr_q  <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (rx_push & full & ~pop) ovr_q <= 1'b1;
         else if (clr_err)          ovr_q <= 1'b0;
      end
   end

endmodule

// File: doc/uart_cfg_core.md
Name: uart_cfg_core

Overview:
- Next-generation UART core for the SoC peripheral bus. Runtime-programmable baud divisor, character length (5-8 bits), parity mode and stop-bit count.
- RX path: parametrised receive FIFO with per-entry parity and framing error flags, plus a sticky overrun flag.
- Both directions use valid/ready handshakes, so the bus wrapper can stream bytes without polling busy/done pulses.

Parameters:
- DIV_WIDTH, 16, width of the runtime baud divisor.
- RX_DEPTH, 4, receive FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- divisor  in  DIV_WIDTH  oversample tick period minus 1, in clk cycles; baud = f_clk / (16*(divisor+1))
- cfg_data_bits  in  2  character length: 00=5, 01=6, 10=7, 11=8
- cfg_parity  in  2  00=none, 01=even, 10=odd, 11=none
- cfg_stop2  in  1  1 = transmit two stop bits
- rx  in  1  serial input, asynchronous to clk
- tx  out  1  serial output
- tx_valid  in  1  byte offered for transmission
- tx_ready  out  1  transmitter can accept a byte
- tx_data  in  8  byte to send; only the low cfg_data_bits bits are used
- tx_busy  out  1  a frame is in progress
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer pops the FIFO head
- rx_data  out  8  FIFO head data, right-justified, unused upper bits 0
- rx_parity_err  out  1  FIFO head parity error
- rx_frame_err  out  1  FIFO head framing error
- rx_overrun  out  1  sticky: a received byte was dropped
- clr_err  in  1  clears rx_overrun

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset values: tx=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, both error flags 0, rx_overrun=0, FIFO empty, both FSMs IDLE, tick counter 0.
- Reset mid-frame aborts the frame immediately; tx returns to 1 asynchronously.
- Tick generator: free-running counter 0..divisor, tick when count==divisor, then wrap to 0. divisor=0 gives a tick every clk. A divisor change takes effect at the next wrap.
- Config latching: cfg_* inputs are latched at frame start (TX accept, RX start detect). Changes mid-frame do not affect the current frame.
- Parity bit: even = XOR of the data bits; odd = its inverse.
- Bit period: 16 ticks for every bit in both directions. Bits are sent LSB first.
- TX FSM, states IDLE, START, DATA, PARITY, STOP:
  - tx_ready = (state==IDLE). Accept on tx_valid & tx_ready; data and config are latched in that cycle.
  - tx falls to 0 on the first tick after accept, then holds each bit for 16 ticks.
  - PARITY state is skipped when parity is none.
  - STOP lasts 16 or 32 ticks; then IDLE, with tx_ready=1 in the following cycle.
  - tx_busy = not IDLE. tx_valid while busy is ignored.
- RX synchroniser: two flops on clk.
- RX FSM, states IDLE, START, DATA, PARITY, STOP:
  - IDLE: the first tick that sees synced rx=0 enters START, resetting the per-bit tick count to 0.
  - START: at tick 8, rx must still be 0, otherwise false start, return to IDLE with nothing pushed.
  - Every later bit: value = majority of three samples taken at per-bit ticks 7, 8, 9, counted from the start-bit midpoint alignment.
  - PARITY is skipped when parity is none. A mismatch sets the entry's parity_err.
  - STOP: only the first stop bit is checked, regardless of cfg_stop2. A sampled 0 sets frame_err.
  - After the stop bit is decided (tick 9 of the stop bit), push {data, parity_err, frame_err} and return to IDLE immediately, so back-to-back frames are received.
- FIFO:
  - Pop on rx_valid & rx_ready.
  - Push while full with no pop in the same cycle: the new entry is dropped and rx_overrun is set.
  - Push while full with a pop in the same cycle: accepted.
  - Simultaneous push and pop when empty: the entry is written, and rx_valid rises the next cycle.
  - Head outputs are stable while rx_valid=1 and no pop occurs.
- rx_overrun: clr_err clears it. If an overrun and clr_err occur in the same cycle, the set wins.
- Pointer arithmetic: log2(RX_DEPTH)-bit pointers wrap naturally; the occupancy count is log2(RX_DEPTH)+1 bits.

Test Plan:
- 8N1, divisor=0, send 0xA5 → tx low for 16 clk, then bits 1,0,1,0,0,1,0,1 at 16 clk each, then high for 16 clk; tx_ready returns 160±1 clk after accept.
- TX looped to RX, 7E2, 0x3C → parity bit 0, TX frame 176 clk; rx_data=0x3C, both error flags 0.
- 8O1 frame of 0x00 driven with parity bit 0 → rx_valid=1, rx_data=0x00, rx_parity_err=1.
- 8N1 frame of 0x55 driven with stop bit 0 → rx_frame_err=1; a following valid 0x12 frame is received cleanly.
- RX_DEPTH=4, rx_ready=0, five frames 0x01..0x05 → pops return 0x01..0x04 in order, rx_overrun=1 until a clr_err pulse; a glitch of 4 ticks low produces no entry.
- Assert rst during DATA of a TX frame → tx=1 at once; after release tx_ready=1 and a new 0x7E frame transmits correctly.
